// File: rtl/sa_tile_sched.sv
// sa_tile_sched: job sequencer for the NxN systolic array (sr_clk domain).
// A job is accepted, the array accumulators are cleared, K vectors are injected,
// pipeline latency is waited out and N result beats are collected.
// A job starts only when the output FIFO has a free slot (credit) for its result.
// Optional build macro: SA_TILE_SCHED_PERF_EN adds busy/stall performance counters.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high.
// Valid is never gated by ready. job_ready and vec_ready depend only on the
// FSM state and the credit count, never on the matching valid.
module sa_tile_sched #(
  parameter int N           = 4,
  parameter int PIPE_LAT    = 7,
  parameter int OUT_CREDITS = 16,
  parameter int ID_W        = 4
) (
  input  logic                  sr_clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [7:0]            job_k_m1,
  input  logic [ID_W-1:0]       job_id,
  input  logic                  vec_valid,
  output logic                  vec_ready,
  output logic                  sa_clear,
  output logic                  sa_in_valid,
  input  logic                  sa_out_valid,
  input  logic [$clog2(N)-1:0]  sa_out_idx,
  input  logic                  credit_ret,
  output logic                  busy,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic                  err_seq,
  output logic                  err_credit,
  output logic [31:0]           perf_busy,
  output logic [31:0]           perf_stall,
  output logic [2:0]            dbg_state
);

  localparam int CW = $clog2(OUT_CREDITS + 1);
  localparam int IW = $clog2(N);
  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   credits;
  logic [7:0]      k_m1_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      inj_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [IW-1:0]   beat_cnt;
  logic            accept;
  logic            credit_ok;
  logic            last_beat;

  assign job_ready   = (state_q == S_IDLE) && (credits != '0);
  assign vec_ready   = (state_q == S_LOAD);
  assign sa_in_valid = vec_valid && vec_ready;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

  assign accept    = job_valid && job_ready;
  // A return while already full has no slot to give back; it is flagged and dropped.
  assign credit_ok = credit_ret && (credits != CW'(OUT_CREDITS));
  assign last_beat = (state_q == S_DRAIN) && sa_out_valid && (beat_cnt == IW'(N - 1));

  // Next-state logic for the job sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CLR;
      S_CLR:   state_d = S_LOAD;
      S_LOAD:  if (sa_in_valid && (inj_cnt == k_m1_q)) state_d = S_FLUSH;
      S_FLUSH: if (flush_cnt == '0) state_d = S_DRAIN;
      S_DRAIN: if (last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sr_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Credit counter: accept consumes one, a valid return restores one.
  always_ff @(posedge sr_clk) begin
    if (rst) begin
      credits <= CW'(OUT_CREDITS);
    end else begin
      case ({accept, credit_ok})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Job latch and the injection / flush / beat counters.
  always_ff @(posedge sr_clk) begin
    if (rst) begin
      k_m1_q    <= '0;
      id_q      <= '0;
      inj_cnt   <= '0;
      flush_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (accept) begin
        k_m1_q   <= job_k_m1;
        id_q     <= job_id;
        inj_cnt  <= '0;
        beat_cnt <= '0;
      end
      if (sa_in_valid) inj_cnt <= inj_cnt + 8'd1;
      if ((state_q == S_LOAD) && (state_d == S_FLUSH)) flush_cnt <= FW'(PIPE_LAT - 1);
      else if ((state_q == S_FLUSH) && (flush_cnt != '0)) flush_cnt <= flush_cnt - FW'(1);
      if ((state_q == S_DRAIN) && sa_out_valid) beat_cnt <= beat_cnt + IW'(1);
    end
  end

  // Registered pulses, completion tag and sticky error flags.
  always_ff @(posedge sr_clk) begin
    if (rst) begin
      sa_clear   <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      err_seq    <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      sa_clear <= accept;
      done     <= last_beat;
      if (last_beat) done_id <= id_q;
      if (sa_out_valid && ((state_q != S_DRAIN) || (sa_out_idx != beat_cnt))) err_seq <= 1'b1;
      if (credit_ret && !credit_ok) err_credit <= 1'b1;
    end
  end

`ifdef SA_TILE_SCHED_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  // Saturating busy-cycle and load-stall counters.
  always_ff @(posedge sr_clk) begin
    if (rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
      if ((state_q == S_LOAD) && !vec_valid && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy  = perf_busy_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_sa_tile_sched.sv
// tb_sa_tile_sched: directed bench for sa_tile_sched (reset, single job, load stall,
// credit exhaustion, sequencing/credit errors, reset during a job).
module tb_sa_tile_sched;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic        sr_clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_k_m1;
  logic [3:0]  job_id;
  logic        vec_valid;
  logic        vec_ready;
  logic        sa_clear;
  logic        sa_in_valid;
  logic        sa_out_valid;
  logic [1:0]  sa_out_idx;
  logic        credit_ret;
  logic        busy;
  logic        done;
  logic [3:0]  done_id;
  logic        err_seq;
  logic        err_credit;
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_credits;
  logic [3:0] exp_q[$];

  sa_tile_sched dut (
    .sr_clk(sr_clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_k_m1(job_k_m1), .job_id(job_id),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .sa_clear(sa_clear), .sa_in_valid(sa_in_valid),
    .sa_out_valid(sa_out_valid), .sa_out_idx(sa_out_idx),
    .credit_ret(credit_ret), .busy(busy), .done(done), .done_id(done_id),
    .err_seq(err_seq), .err_credit(err_credit),
    .perf_busy(perf_busy), .perf_stall(perf_stall), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 sr_clk = ~sr_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sr_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    job_valid = 1'b0; job_k_m1 = '0; job_id = '0; vec_valid = 1'b0;
    sa_out_valid = 1'b0; sa_out_idx = '0; credit_ret = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_credits = 16;
    exp_q.delete();
  endtask

  // Driver: runs one complete job. gap_at/gap_len drop vec_valid for gap_len cycles
  // once gap_at vectors have been injected; swap returns beats in order 0,2,1,3;
  // ret pulses credit_ret in the accept cycle.
  task automatic run_job(input logic [7:0] k_m1, input logic [3:0] id, input int gap_at,
                         input int gap_len, input bit swap, input bit ret);
    int inj, gaps, gap_inj, cyc, fl, leak, clr_extra;
    int ord[4];
    logic [3:0] exp_id;
    ord[0] = 0; ord[1] = swap ? 2 : 1; ord[2] = swap ? 1 : 2; ord[3] = 3;
    cyc = 0;
    while (!job_ready && cyc < 100) begin tick(); cyc++; end
    check("job_ready_before_accept", job_ready, 1);
    job_valid = 1'b1; job_k_m1 = k_m1; job_id = id; credit_ret = ret;
    tick();
    job_valid = 1'b0; credit_ret = 1'b0;
    exp_credits = exp_credits - 1 + (ret ? 1 : 0);
    exp_q.push_back(id);
    vec_valid = 1'b1;
    #1;
    check("clr_state", dbg_state, ST_CLR);
    check("clr_sa_clear", sa_clear, 1);
    check("clr_vec_ready", vec_ready, 0);
    check("clr_no_inject", sa_in_valid, 0);
    check("clr_busy", busy, 1);
    check("clr_job_ready", job_ready, 0);
    check("credits_after_accept", dut.credits, exp_credits);
    tick();
    inj = 0; gaps = 0; gap_inj = 0; cyc = 0; clr_extra = 0;
    while (dbg_state == ST_LOAD && cyc < 1000) begin
      if (gap_len > 0 && inj == gap_at && gaps < gap_len) begin
        vec_valid = 1'b0; gaps++;
      end else begin
        vec_valid = 1'b1;
      end
      #1;
      if (sa_in_valid) begin inj++; if (!vec_valid) gap_inj++; end
      if (sa_clear) clr_extra++;
      tick();
      cyc++;
    end
    check("inject_count", inj, 32'(k_m1) + 1);
    check("inject_in_gap", gap_inj, 0);
    check("load_cycles", cyc, 32'(k_m1) + 1 + gaps);
    check("sa_clear_single", clr_extra, 0);
    vec_valid = 1'b1;
    fl = 0; leak = 0;
    #1;
    while (dbg_state == ST_FLUSH && fl < 100) begin
      if (sa_in_valid) leak++;
      tick();
      fl++;
    end
    vec_valid = 1'b0;
    check("flush_len", fl, 7);
    check("flush_no_inject", leak, 0);
    check("drain_state", dbg_state, ST_DRAIN);
    for (int b = 0; b < 4; b++) begin
      sa_out_valid = 1'b1;
      sa_out_idx = 2'(ord[b]);
      check("no_early_done", done, 0);
      tick();
      if (b < 3) check("drain_hold", dbg_state, ST_DRAIN);
    end
    sa_out_valid = 1'b0;
    exp_id = exp_q.pop_front();
    check("done_pulse", done, 1);
    check("done_id", done_id, exp_id);
    check("idle_after_drain", dbg_state, ST_IDLE);
    check("busy_after_drain", busy, 0);
    check("credits_after_job", dut.credits, exp_credits);
    tick();
    check("done_one_cycle", done, 0);
    check("done_id_hold", done_id, exp_id);
  endtask

  initial begin
    int seen_done;

    // 1 Reset
    do_reset();
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_seq", err_seq, 0);
    check("rst_err_credit", err_credit, 0);
    check("rst_credits", dut.credits, 16);
    check("rst_sa_clear", sa_clear, 0);
    check("rst_done_id", done_id, 0);
    check("rst_perf_busy", perf_busy, 0);
    check("rst_perf_stall", perf_stall, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // 2 Single job
    run_job(8'd3, 4'd5, 0, 0, 1'b0, 1'b0);
    check("single_credits", dut.credits, 15);
    check("single_err_seq", err_seq, 0);

    // 3 Load stall of 3 cycles after two injections
    do_reset();
    run_job(8'd3, 4'd7, 2, 3, 1'b0, 1'b0);
`ifdef SA_TILE_SCHED_PERF_EN
    check("perf_stall", perf_stall, 3);
    check("perf_busy", perf_busy, 19);
`else
    check("perf_stall", perf_stall, 0);
    check("perf_busy", perf_busy, 0);
`endif

    // 4 Credit exhaustion
    do_reset();
    for (int j = 0; j < 16; j++) run_job(8'd0, 4'(j), 0, 0, 1'b0, 1'b0);
    check("exhaust_credits", dut.credits, 0);
    check("exhaust_job_ready", job_ready, 0);
    job_valid = 1'b1; job_k_m1 = 8'd0; job_id = 4'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("pending_state", dbg_state, ST_IDLE);
      check("pending_ready", job_ready, 0);
    end
    job_valid = 1'b0;
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    exp_credits = exp_credits + 1;
    check("ret_job_ready", job_ready, 1);
    check("ret_credits", dut.credits, 1);
    run_job(8'd1, 4'd12, 0, 0, 1'b0, 1'b1);
    check("accept_and_ret_credits", dut.credits, 1);

    // 5 Errors
    do_reset();
    run_job(8'd3, 4'd9, 0, 0, 1'b1, 1'b0);
    check("err_seq_order", err_seq, 1);
    check("err_credit_clean", err_credit, 0);
    credit_ret = 1'b1;
    tick();
    check("ret_to_max", dut.credits, 16);
    check("ret_to_max_no_err", err_credit, 0);
    tick();
    credit_ret = 1'b0;
    check("ret_at_max_err", err_credit, 1);
    check("ret_at_max_credits", dut.credits, 16);
    tick();
    check("err_credit_sticky", err_credit, 1);
    check("err_seq_sticky", err_seq, 1);
    do_reset();
    check("err_cleared_by_rst", err_seq, 0);
    sa_out_valid = 1'b1;
    tick();
    sa_out_valid = 1'b0;
    check("err_seq_beat_in_idle", err_seq, 1);

    // 6 Reset during LOAD
    do_reset();
    job_valid = 1'b1; job_k_m1 = 8'd7; job_id = 4'd3;
    tick();
    job_valid = 1'b0;
    vec_valid = 1'b1;
    tick();
    tick();
    tick();
    check("mid_job_state", dbg_state, ST_LOAD);
    check("mid_job_credits", dut.credits, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_valid = 1'b0;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_credits", dut.credits, 16);
    check("abort_job_ready", job_ready, 1);
    check("abort_done", done, 0);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_stays_idle", dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
